psg_multi: RTL and testbench

PSG_MULTI -- requirements
Module: psg_multi

---
 rtl/psg_multi.sv | 188 ++++++++++++++++++
 tb/tb_psg_multi.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_multi.sv
// psg_multi: up to four tone/noise channels, nibble-wide write bus, mixer.
// CLK/RST(async low), D/A0/WR write bus -> SIG per-channel bits, SAMPLE mix.
module psg_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 12,
  parameter int OUT_W  = 6,
  parameter int PRE    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        D,
  input  logic              A0,
  input  logic              WR,
  output logic [NUM_CH-1:0] SIG,
  output logic [OUT_W-1:0]  SAMPLE
);

  localparam int NIB = DIV_W / 4;
  localparam int PW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int SW  = 9;

  localparam logic [SW-1:0] SMAX = SW'((1 << OUT_W) - 1);
  localparam logic [PW-1:0] LAST = PW'(NIB - 1);
  localparam logic [CW-1:0] PMAX = CW'(PRE - 1);

  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_ch
    $error("NUM_CH out of range");
  end
  if (DIV_W < 4 || DIV_W > 16 || (DIV_W % 4) != 0) begin : g_bad_dw
    $error("DIV_W out of range");
  end
  if (OUT_W < 4 || OUT_W > 8) begin : g_bad_ow
    $error("OUT_W out of range");
  end
  if (PRE < 1 || PRE > 256) begin : g_bad_pre
    $error("PRE out of range");
  end

  logic              wr_q, wr_d;
  logic [3:0]        addr_q, addr_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [DIV_W-1:0]  shad_q, shad_d;
  logic [DIV_W-1:0]  shad_nx;
  logic [CW-1:0]     pre_q, pre_d;
  logic [OUT_W-1:0]  smp_q, smp_d;

  logic              wr_ev;
  logic              tick;
  logic              ch_ok;
  logic              last_nib;
  logic [1:0]        ch;
  logic [1:0]        rg;
  logic [4*NUM_CH-1:0] vol_v;
  logic [SW-1:0]     sum;

  assign wr_ev    = WR & ~wr_q;
  assign tick     = (pre_q == PMAX);
  assign ch       = addr_q[3:2];
  assign rg       = addr_q[1:0];
  assign ch_ok    = (int'(ch) < NUM_CH);
  assign last_nib = (ptr_q == LAST);

  // Shadow with the incoming nibble merged in at the current pointer.
  always_comb begin
    shad_nx = shad_q;
    shad_nx[{ptr_q, 2'b00} +: 4] = D;
  end

  always_comb begin
    wr_d   = WR;
    addr_d = addr_q;
    ptr_d  = ptr_q;
    shad_d = shad_q;
    pre_d  = tick ? '0 : pre_q + CW'(1);
    if (wr_ev) begin
      if (!A0) begin
        addr_d = D;
        ptr_d  = '0;
      end else if (ch_ok && rg == 2'd0) begin
        shad_d = shad_nx;
        ptr_d  = last_nib ? '0 : ptr_q + PW'(1);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (SIG[c]) begin
        sum = sum + SW'(vol_v[4*c +: 4]);
      end
    end
    smp_d = (sum > SMAX) ? SMAX[OUT_W-1:0] : sum[OUT_W-1:0];
  end

  // WR history resets to "high" so a strobe held across the
  // release of RST must first be seen low before it can write.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q   <= 1'b1;
      addr_q <= '0;
      ptr_q  <= '0;
      shad_q <= '0;
      pre_q  <= '0;
      smp_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      ptr_q  <= ptr_d;
      shad_q <= shad_d;
      pre_q  <= pre_d;
      smp_q  <= smp_d;
    end
  end

  assign SAMPLE = smp_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sel;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [3:0]       vol_q, vol_d;
    logic             mode_q, mode_d;
    logic             sq_q, sq_d;
    logic [14:0]      lfsr_q, lfsr_d;
    logic [14:0]      lfsr_nx;

    assign sel     = wr_ev & A0 & (ch == 2'(c));
    assign lfsr_nx = {lfsr_q[1] ^ lfsr_q[0], lfsr_q[14:1]};

    // Counter logic uses per_q, so a commit on a reload
    // edge only shows up at the following reload.
    always_comb begin
      per_d  = per_q;
      vol_d  = vol_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      sq_d   = sq_q;
      lfsr_d = lfsr_q;
      if (sel && rg == 2'd0 && last_nib) begin
        per_d = shad_nx;
      end
      if (sel && rg == 2'd1) begin
        vol_d = D;
      end
      if (sel && rg == 2'd2) begin
        mode_d = D[0];
      end
      if (tick) begin
        if (per_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          cnt_d = per_q - DIV_W'(1);
          if (mode_q) begin
            lfsr_d = lfsr_nx;
          end else begin
            sq_d = ~sq_q;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        per_q  <= '0;
        cnt_q  <= '0;
        vol_q  <= '0;
        mode_q <= 1'b0;
        sq_q   <= 1'b0;
        lfsr_q <= 15'h0001;
      end else begin
        per_q  <= per_d;
        cnt_q  <= cnt_d;
        vol_q  <= vol_d;
        mode_q <= mode_d;
        sq_q   <= sq_d;
        lfsr_q <= lfsr_d;
      end
    end

    assign SIG[c] = (per_q != '0) & (mode_q ? lfsr_q[0] : sq_q);
    assign vol_v[4*c +: 4] = vol_q;
  end

endmodule

// File: tb/tb_psg_multi.sv
// tb_psg_multi: three psg_multi configurations on one shared write bus,
// checked every cycle against an integer model plus directed literal checks.
module tb_psg_multi;

  localparam int NK = 3;

  int P_NCH[NK] = '{4, 4, 2};
  int P_DW[NK]  = '{12, 8, 4};
  int P_OW[NK]  = '{6, 5, 4};
  int P_PRE[NK] = '{1, 3, 2};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] D   = '0;
  logic       A0  = 1'b0;
  logic       WR  = 1'b0;

  logic [3:0] sig0;
  logic [5:0] smp0;
  logic [3:0] sig1;
  logic [4:0] smp1;
  logic [1:0] sig2;
  logic [3:0] smp2;

  psg_multi #(.NUM_CH(4), .DIV_W(12), .OUT_W(6), .PRE(1)) u0 (
    .CLK(CLK), .RST(RST), .D(D), .A0(A0), .WR(WR),
    .SIG(sig0), .SAMPLE(smp0)
  );
  psg_multi #(.NUM_CH(4), .DIV_W(8), .OUT_W(5), .PRE(3)) u1 (
    .CLK(CLK), .RST(RST), .D(D), .A0(A0), .WR(WR),
    .SIG(sig1), .SAMPLE(smp1)
  );
  psg_multi #(.NUM_CH(2), .DIV_W(4), .OUT_W(4), .PRE(2)) u2 (
    .CLK(CLK), .RST(RST), .D(D), .A0(A0), .WR(WR),
    .SIG(sig2), .SAMPLE(smp2)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model state, one row per configuration
  int m_wrp[NK], m_addr[NK], m_ptr[NK], m_sh[NK], m_pre[NK], m_smp[NK];
  int m_per[NK][4], m_cnt[NK][4], m_vol[NK][4];
  int m_mode[NK][4], m_sq[NK][4], m_lf[NK][4];

  function automatic int lfsr_nx(int v);
    return ((v >> 1) | (((v ^ (v >> 1)) & 1) << 14)) & 32'h7fff;
  endfunction

  function automatic int msig(int k, int c);
    if (c >= P_NCH[k] || m_per[k][c] == 0) return 0;
    return m_mode[k][c] != 0 ? (m_lf[k][c] & 1) : m_sq[k][c];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NK; k++) begin
      m_wrp[k] = 1; m_addr[k] = 0; m_ptr[k] = 0;
      m_sh[k] = 0; m_pre[k] = 0; m_smp[k] = 0;
      for (int c = 0; c < 4; c++) begin
        m_per[k][c] = 0; m_cnt[k][c] = 0; m_vol[k][c] = 0;
        m_mode[k][c] = 0; m_sq[k][c] = 0; m_lf[k][c] = 1;
      end
    end
  endtask

  task automatic m_step(int k);
    int sum, mx, ch, rg, sh, d, sft;
    d = int'(D);
    sum = 0;
    for (int c = 0; c < P_NCH[k]; c++)
      if (msig(k, c) != 0) sum += m_vol[k][c];
    mx = (1 << P_OW[k]) - 1;
    m_smp[k] = (sum > mx) ? mx : sum;
    if (m_pre[k] == P_PRE[k] - 1) begin
      m_pre[k] = 0;
      for (int c = 0; c < P_NCH[k]; c++) begin
        if (m_per[k][c] == 0) m_cnt[k][c] = 0;
        else if (m_cnt[k][c] == 0) begin
          m_cnt[k][c] = m_per[k][c] - 1;
          if (m_mode[k][c] != 0) m_lf[k][c] = lfsr_nx(m_lf[k][c]);
          else m_sq[k][c] = 1 - m_sq[k][c];
        end else m_cnt[k][c] -= 1;
      end
    end else m_pre[k] += 1;
    if (WR && m_wrp[k] == 0) begin
      if (!A0) begin
        m_addr[k] = d; m_ptr[k] = 0;
      end else begin
        ch = m_addr[k] / 4; rg = m_addr[k] % 4;
        if (ch < P_NCH[k]) begin
          if (rg == 0) begin
            sft = 4 * m_ptr[k];
            sh = (m_sh[k] & ~(15 << sft)) | (d << sft);
            m_sh[k] = sh;
            if (m_ptr[k] == P_DW[k] / 4 - 1) begin
              m_per[k][ch] = sh; m_ptr[k] = 0;
            end else m_ptr[k] += 1;
          end
          if (rg == 1) m_vol[k][ch] = d;
          if (rg == 2) m_mode[k][ch] = d & 1;
        end
      end
    end
    m_wrp[k] = WR ? 1 : 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) m_reset();
      else for (int k = 0; k < NK; k++) m_step(k);
    end
  end

  function automatic int dsig(int k);
    if (k == 0) return int'(sig0);
    if (k == 1) return int'(sig1);
    return int'(sig2);
  endfunction

  function automatic int dsmp(int k);
    if (k == 0) return int'(smp0);
    if (k == 1) return int'(smp1);
    return int'(smp2);
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_on) begin
        for (int k = 0; k < NK; k++) begin
          int e;
          e = 0;
          for (int c = 0; c < P_NCH[k]; c++) e |= msig(k, c) << c;
          n_cmp++;
          if (dsig(k) != e) begin
            n_bad++;
            $display("FAIL sig%0d t=%0t: got %0h expected %0h",
                     k, $time, dsig(k), e);
          end
          n_cmp++;
          if (dsmp(k) != m_smp[k]) begin
            n_bad++;
            $display("FAIL sample%0d t=%0t: got %0d expected %0d",
                     k, $time, dsmp(k), m_smp[k]);
          end
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wr(bit a, int d);
    A0 = a; D = d[3:0]; WR = 1'b1;
    cyc(1);
    WR = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    cyc(1);
    RST = 1'b1;
    cyc(1);
  endtask

  task automatic set_per(int ch, int p);
    wr(1'b0, ch * 4);
    wr(1'b1, p & 15);
    wr(1'b1, (p >> 4) & 15);
    wr(1'b1, (p >> 8) & 15);
  endtask

  task automatic set_reg(int ch, int r, int v);
    wr(1'b0, ch * 4 + r);
    wr(1'b1, v);
  endtask

  // Cycles between two consecutive edges of SIG[0] on config 0.
  task automatic measure(string nm, int exp);
    int n;
    logic prev;
    prev = sig0[0]; n = 0;
    while (sig0[0] == prev && n < 200) begin cyc(1); n++; end
    if (n >= 200) begin chk({nm, "_timeout"}, n, 0); return; end
    prev = sig0[0]; n = 0;
    while (sig0[0] == prev && n < 200) begin cyc(1); n++; end
    chk(nm, n, exp);
  endtask

  int hist[64];
  int v, n;
  bit f0, f1;
  logic pv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pins: known LFSR steps and full period
    chk("lfsr_step1", lfsr_nx(1), 32'h4000);
    chk("lfsr_step2", lfsr_nx(32'h4000), 32'h2000);
    v = 1; n = 0;
    do begin v = lfsr_nx(v); n++; end while (v != 1 && n < 40000);
    chk("lfsr_period", n, 32767);

    #1 RST = 1'b0;
    cyc(2);
    chk_on = 1'b1;
    chk("rst_sig0", int'(sig0), 0);
    chk("rst_smp0", int'(smp0), 0);
    chk("rst_sig2", int'(sig2), 0);
    chk("rst_smp1", int'(smp1), 0);
    RST = 1'b1;
    cyc(2);

    // Tone: period 4 toggles every 4 CLK, SAMPLE lags by one
    set_per(0, 4);
    set_reg(0, 1, 15);
    measure("tone_iv", 4);
    for (int i = 0; i < 12; i++) begin
      pv = sig0[0];
      cyc(1);
      chk("tone_lag", int'(smp0), pv ? 15 : 0);
    end

    // Saturation on all four channels
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_per(c, 1);
      set_reg(c, 1, 15);
    end
    f0 = 0; f1 = 0;
    for (int i = 0; i < 16; i++) begin
      bit s0, s1;
      s0 = (sig0 == 4'hF);
      s1 = (sig1 == 4'hF);
      cyc(1);
      if (s0 && !f0) begin chk("sat_w6", int'(smp0), 60); f0 = 1; end
      if (s1 && !f1) begin chk("sat_w5", int'(smp1), 31); f1 = 1; end
    end
    chk("sat_w6_seen", int'(f0), 1);
    chk("sat_w5_seen", int'(f1), 1);

    // Partial period write keeps old rate until final nibble
    do_reset();
    set_per(0, 16);
    measure("part_old", 16);
    wr(1'b0, 0);
    wr(1'b1, 8);
    wr(1'b1, 0);
    measure("part_hold", 16);
    wr(1'b1, 0);
    measure("part_new", 8);

    // Noise: first outputs 1,0,0,0 then period 32767
    do_reset();
    set_reg(0, 2, 1);
    wr(1'b0, 0);
    wr(1'b1, 1);
    wr(1'b1, 0);
    A0 = 1'b1; D = 4'h0; WR = 1'b1;
    cyc(1);
    chk("noise_v0", int'(sig0[0]), 1);
    WR = 1'b0;
    cyc(1);
    chk("noise_v1", int'(sig0[0]), 0);
    cyc(1);
    chk("noise_v2", int'(sig0[0]), 0);
    cyc(1);
    chk("noise_v3", int'(sig0[0]), 0);
    for (int i = 0; i < 64; i++) begin cyc(1); hist[i] = int'(sig0[0]); end
    cyc(32767 - 64);
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      chk("noise_repeat", int'(sig0[0]), hist[i]);
    end

    // WR held high for 10 CLK advances only one nibble
    do_reset();
    wr(1'b0, 0);
    A0 = 1'b1; D = 4'h5; WR = 1'b1;
    cyc(10);
    WR = 1'b0;
    cyc(1);
    wr(1'b1, 0);
    wr(1'b1, 0);
    measure("strobe_iv", 5);

    // WR held through reset release is not a write
    A0 = 1'b1; D = 4'h3; WR = 1'b1;
    RST = 1'b0;
    cyc(2);
    RST = 1'b1;
    cyc(3);
    WR = 1'b0;
    cyc(1);
    wr(1'b1, 2);
    wr(1'b1, 0);
    wr(1'b1, 0);
    measure("rel_iv", 2);

    // Writes to absent channels and reserved register ignored
    do_reset();
    set_reg(3, 0, 1);
    set_reg(3, 1, 15);
    set_reg(0, 3, 7);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("filt_sig2", int'(sig2), 0);
      chk("filt_smp2", int'(smp2), 0);
    end

    // Reset while running and mid period write
    do_reset();
    set_per(0, 3);
    set_reg(0, 1, 9);
    set_per(1, 2);
    set_reg(1, 1, 6);
    cyc(5);
    wr(1'b0, 0);
    wr(1'b1, 1);
    wr(1'b1, 1);
    RST = 1'b0;
    #1;
    chk("mid_sig0", int'(sig0), 0);
    chk("mid_smp0", int'(smp0), 0);
    chk("mid_sig1", int'(sig1), 0);
    chk("mid_smp1", int'(smp1), 0);
    cyc(1);
    RST = 1'b1;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("mid_quiet", int'(sig0) + int'(smp0), 0);
    end
    wr(1'b1, 2);
    wr(1'b1, 0);
    wr(1'b1, 0);
    measure("mid_iv", 2);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else if (r < 30) begin
        wr(1'b0, $urandom_range(0, 15));
      end else if (r < 85) begin
        A0 = 1'b1;
        D = 4'($urandom_range(0, 15));
        WR = 1'b1;
        cyc($urandom_range(1, 3));
        WR = 1'b0;
        cyc($urandom_range(1, 2));
      end else begin
        cyc($urandom_range(1, 20));
      end
    end
    cyc(4);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
